// File: rtl/filter_weight_reader.sv
// Read-side sequencer for the filter-major weight buffer. Walks every
// (row, filter) pair, reads a synchronous RAM and streams each word out
// through a 2-entry buffer with filter/row tags and frame-end flags.
module filter_weight_reader #(
  parameter int NUM_FILTERS = 9,
  parameter int NUM_ROWS    = 24,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int FIDX_W      = 4,
  parameter int RIDX_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [FIDX_W-1:0] out_filter,
  output logic [RIDX_W-1:0] out_row,
  output logic              out_last_filter,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  localparam logic [FIDX_W-1:0] FILT_LAST = FIDX_W'(NUM_FILTERS - 1);
  localparam logic [RIDX_W-1:0] ROW_LAST  = RIDX_W'(NUM_ROWS - 1);

  logic [1:0]        state;
  logic [FIDX_W-1:0] filt_cnt;
  logic [RIDX_W-1:0] row_cnt;
  logic [ADDR_W-1:0] addr_cnt;

  // Read-issue stage: tags of the word currently in flight from the RAM
  logic              rd_vld_p0;
  logic [FIDX_W-1:0] rd_filt_p0;
  logic [RIDX_W-1:0] rd_row_p0;

  // Output buffer stage: two-entry circular buffer
  logic [DATA_W-1:0] wbuf_data [2];
  logic [FIDX_W-1:0] wbuf_filt [2];
  logic [RIDX_W-1:0] wbuf_row  [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  logic              pop;
  logic              issue;
  logic              last_issue;
  logic [2:0]        credit_used;

  // A slot is reserved for every word buffered or in flight; the word leaving
  // this cycle frees its slot immediately so steady state runs at full rate.
  assign pop         = out_valid & out_ready;
  assign credit_used = {1'b0, count} + {2'b0, rd_vld_p0} - {2'b0, pop};
  assign issue       = (state == READ) && (credit_used < 3'd2);
  assign last_issue  = issue && (filt_cnt == FILT_LAST) && (row_cnt == ROW_LAST);

  assign mem_rd_en = issue;
  assign mem_addr  = issue ? addr_cnt : '0;

  assign out_valid       = (count != 2'd0);
  assign out_data        = wbuf_data[rd_ptr];
  assign out_filter      = wbuf_filt[rd_ptr];
  assign out_row         = wbuf_row[rd_ptr];
  assign out_last_filter = out_valid && (out_filter == FILT_LAST);
  assign out_last        = out_last_filter && (out_row == ROW_LAST);

  assign busy = (state == READ) || (state == DRAIN);
  assign done = (state == FIN);

  // Frame sequencing and the filter/row/address issue counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      filt_cnt <= '0;
      row_cnt  <= '0;
      addr_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= READ;
            filt_cnt <= '0;
            row_cnt  <= '0;
            addr_cnt <= '0;
          end
        end
        READ: begin
          if (issue) begin
            // Running address equals row*NUM_FILTERS + filter
            addr_cnt <= addr_cnt + ADDR_W'(1);
            if (filt_cnt == FILT_LAST) begin
              filt_cnt <= '0;
              row_cnt  <= row_cnt + RIDX_W'(1);
            end else begin
              filt_cnt <= filt_cnt + FIDX_W'(1);
            end
            if (last_issue) state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((count == 2'd0) && !rd_vld_p0) state <= FIN;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Track the outstanding read so its data is captured one cycle after issue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld_p0  <= 1'b0;
      rd_filt_p0 <= '0;
      rd_row_p0  <= '0;
    end else begin
      rd_vld_p0  <= issue;
      rd_filt_p0 <= filt_cnt;
      rd_row_p0  <= row_cnt;
    end
  end

  // Capture returned words with their tags and release them downstream
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        wbuf_data[i] <= '0;
        wbuf_filt[i] <= '0;
        wbuf_row[i]  <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (rd_vld_p0) begin
        wbuf_data[wr_ptr] <= mem_rdata;
        wbuf_filt[wr_ptr] <= rd_filt_p0;
        wbuf_row[wr_ptr]  <= rd_row_p0;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({rd_vld_p0, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_weight_reader.sv
// Testbench for filter_weight_reader: default-size instance exercised with
// full-rate, stalled, random-ready, held-start and mid-frame reset frames,
// plus a 3x2 instance for the small-geometry case.
module tb_filter_weight_reader;

  localparam int NF = 9;
  localparam int NR = 24;
  localparam int TOTAL = NF * NR;
  localparam int SNF = 3;
  localparam int SNR = 2;
  localparam int STOTAL = SNF * SNR;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, out_ready;
  logic       mem_rd_en;
  logic [7:0] mem_addr, mem_rdata, out_data;
  logic       out_valid, out_last_filter, out_last, busy, done;
  logic [3:0] out_filter;
  logic [4:0] out_row;

  logic       s_start, s_ready, s_rd_en, s_valid, s_lastf, s_last, s_busy, s_done;
  logic [7:0] s_addr, s_rdata, s_data;
  logic [3:0] s_filter;
  logic [4:0] s_row;

  filter_weight_reader dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_filter(out_filter), .out_row(out_row),
    .out_last_filter(out_last_filter), .out_last(out_last),
    .busy(busy), .done(done)
  );

  filter_weight_reader #(.NUM_FILTERS(SNF), .NUM_ROWS(SNR)) dut_small (
    .clk(clk), .reset(reset), .start(s_start),
    .mem_rd_en(s_rd_en), .mem_addr(s_addr), .mem_rdata(s_rdata),
    .out_valid(s_valid), .out_ready(s_ready), .out_data(s_data),
    .out_filter(s_filter), .out_row(s_row),
    .out_last_filter(s_lastf), .out_last(s_last),
    .busy(s_busy), .done(s_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // RAM contents: an injective scramble of the address
  function automatic logic [7:0] ram_word(input logic [7:0] a);
    logic [15:0] t;
    t = 16'(a) * 16'd37 + 16'd11;
    return t[7:0];
  endfunction

  // Synchronous RAMs; garbage is returned when no read was issued
  always @(posedge clk) begin
    mem_rdata <= mem_rd_en ? ram_word(mem_addr) : 8'($urandom);
    s_rdata   <= s_rd_en ? ram_word(s_addr) : 8'($urandom);
  end

  // Reference model state for the default instance
  int cyc = 0, k = 0, exp_addr = 0, issued = 0, accepted = 0;
  int lf_cnt = 0, last_cnt = 0, first_hs = 0, last_hs = -100, done_cnt = 0;
  int snap_words = 0, snap_lf = 0, snap_last = 0, snap_span = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic [3:0] prev_f = '0;
  logic [4:0] prev_r = '0;

  // Compare process: word k of a frame is address k, filter k%NF, row k/NF
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        k = 0; exp_addr = 0; issued = 0; accepted = 0;
        lf_cnt = 0; last_cnt = 0; prev_stall = 1'b0; last_hs = -100;
      end else begin
        if (mem_rd_en) begin
          check("rd_addr", 32'(mem_addr), 32'(exp_addr));
          exp_addr++;
          issued++;
        end
        if (prev_stall) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'(out_data), 32'(prev_data));
          check("hold_filter", 32'(out_filter), 32'(prev_f));
          check("hold_row", 32'(out_row), 32'(prev_r));
        end
        if (out_valid && out_ready) begin
          check("data", 32'(out_data), 32'(ram_word(8'(k))));
          check("filter", 32'(out_filter), 32'(k % NF));
          check("row", 32'(out_row), 32'(k / NF));
          check("last_filter", 32'(out_last_filter), 32'((k % NF) == NF - 1));
          check("last", 32'(out_last), 32'(k == TOTAL - 1));
          if (out_last_filter) lf_cnt++;
          if (out_last) begin last_cnt++; last_hs = cyc; end
          if (k == 0) first_hs = cyc;
          k++;
          accepted++;
        end
        check("outstanding_le2", 32'((issued - accepted) <= 2), 32'd1);
        prev_stall = out_valid && !out_ready;
        prev_data = out_data; prev_f = out_filter; prev_r = out_row;
        if (done) begin
          check("done_delay", 32'(cyc - last_hs), 32'd2);
          done_cnt++;
          snap_words = k; snap_lf = lf_cnt; snap_last = last_cnt;
          snap_span = last_hs - first_hs;
          k = 0; exp_addr = 0; issued = 0; accepted = 0; lf_cnt = 0; last_cnt = 0;
        end
      end
    end
  end

  // Reference model for the 3x2 instance
  int sk = 0, s_exp = 0, s_done_cnt = 0, s_snap = 0, s_last_k = -1;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        sk = 0; s_exp = 0;
      end else begin
        if (s_rd_en) begin
          check("s_rd_addr", 32'(s_addr), 32'(s_exp));
          s_exp++;
        end
        if (s_valid && s_ready) begin
          check("s_data", 32'(s_data), 32'(ram_word(8'(sk))));
          check("s_filter", 32'(s_filter), 32'(sk % SNF));
          check("s_row", 32'(s_row), 32'(sk / SNF));
          check("s_last_filter", 32'(s_lastf), 32'((sk % SNF) == SNF - 1));
          check("s_last", 32'(s_last), 32'(sk == STOTAL - 1));
          if (s_last) s_last_k = sk;
          sk++;
        end
        if (s_done) begin
          s_done_cnt++;
          s_snap = sk;
          sk = 0; s_exp = 0;
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_frame(input int limit);
    int d0;
    logic got;
    d0 = done_cnt;
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      if (done_cnt > d0) begin got = 1'b1; break; end
    end
    check("frame_done_in_time", 32'(got), 32'd1);
  endtask

  task automatic wait_words(input int n, input int limit);
    logic got;
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #2;
      if (k >= n) begin got = 1'b1; break; end
    end
    check("reach_word", 32'(got), 32'd1);
  endtask

  initial begin
    int d0, idle_bad;
    logic got;
    reset = 1'b0; start = 1'b0; out_ready = 1'b1;
    s_start = 1'b0; s_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    @(posedge clk); #2 reset = 1'b1;

    // 3x2 geometry
    @(posedge clk); #2 s_start = 1'b1;
    @(posedge clk); #2 s_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (s_done_cnt > 0) begin got = 1'b1; break; end
    end
    check("s_frame_done", 32'(got), 32'd1);
    check("s_words", 32'(s_snap), 32'd6);
    check("s_last_index", 32'(s_last_k), 32'd5);
    repeat (5) @(posedge clk);
    check("s_done_once", 32'(s_done_cnt), 32'd1);
    check("s_busy_after", 32'(s_busy), 32'd0);

    // Full-rate frame with latency pins
    d0 = done_cnt;
    pulse_start();
    #4;
    check("lat_c1_rd_en", 32'(mem_rd_en), 32'd1);
    check("lat_c1_addr", 32'(mem_addr), 32'd0);
    check("lat_c1_busy", 32'(busy), 32'd1);
    check("lat_c1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #6;
    check("lat_c2_valid", 32'(out_valid), 32'd0);
    check("lat_c2_addr", 32'(mem_addr), 32'd1);
    @(posedge clk); #6;
    check("lat_c3_valid", 32'(out_valid), 32'd1);
    check("lat_c3_data", 32'(out_data), 32'd11);
    wait_frame(1000);
    check("f1_words", 32'(snap_words), 32'd216);
    check("f1_last_filter_cnt", 32'(snap_lf), 32'd24);
    check("f1_last_cnt", 32'(snap_last), 32'd1);
    check("f1_span_full_rate", 32'(snap_span), 32'd215);
    repeat (10) @(posedge clk);
    #1;
    check("f1_done_once", 32'(done_cnt - d0), 32'd1);
    check("f1_busy_after", 32'(busy), 32'd0);

    // Backpressure at word 50
    pulse_start();
    wait_words(50, 500);
    out_ready = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_data", 32'(out_data), 32'd69);
    check("stall_filter", 32'(out_filter), 32'd5);
    check("stall_row", 32'(out_row), 32'd5);
    check("stall_count", 32'(k), 32'd50);
    out_ready = 1'b1;
    wait_frame(1000);
    check("bp_words", 32'(snap_words), 32'd216);

    // Random ready
    d0 = done_cnt;
    pulse_start();
    got = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      out_ready = 1'($urandom_range(0, 1));
      if (done_cnt > d0) begin got = 1'b1; break; end
    end
    out_ready = 1'b1;
    check("rand_frame_done", 32'(got), 32'd1);
    check("rand_words", 32'(snap_words), 32'd216);

    // start held high through the whole frame and FIN
    @(posedge clk); #2 start = 1'b1;
    wait_frame(1000);
    check("held_words", 32'(snap_words), 32'd216);
    #4;
    check("held_idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #4;
    check("held_restart_busy", 32'(busy), 32'd1);
    check("held_restart_rd", 32'(mem_rd_en), 32'd1);
    check("held_restart_addr", 32'(mem_addr), 32'd0);
    start = 1'b0;
    wait_frame(1000);
    check("held_words2", 32'(snap_words), 32'd216);
    idle_bad = 0;
    repeat (20) begin
      @(posedge clk); #4;
      if (mem_rd_en || busy) idle_bad++;
    end
    check("no_third_frame", 32'(idle_bad), 32'd0);

    // Asynchronous reset mid-frame at word 100
    pulse_start();
    wait_words(100, 500);
    reset = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_rd_en", 32'(mem_rd_en), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    check("arst_filter", 32'(out_filter), 32'd0);
    check("arst_row", 32'(out_row), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    idle_bad = 0;
    repeat (3) begin
      @(posedge clk); #4;
      if (mem_rd_en || busy || out_valid) idle_bad++;
    end
    check("post_rst_idle", 32'(idle_bad), 32'd0);
    pulse_start();
    wait_frame(1000);
    check("post_rst_words", 32'(snap_words), 32'd216);
    check("post_rst_last_cnt", 32'(snap_last), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
